// File: rtl/i2s_pkg.sv
// Shared constants and saturation helper for the i2s sample path.
package i2s_pkg;

    localparam int unsigned I2S_WORD_W = 32;
    localparam int unsigned PCM_W      = 24;
    localparam int unsigned SAMPLE_W   = 16;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic [SAMPLE_W-1:0]     sample_t;

    // SAT_MAX / SAT_MIN as signed PCM-width values for range comparison
    localparam pcm_t PCM_HI = 24'sh007FFF;
    localparam pcm_t PCM_LO = 24'shFF8000;

    // Clamp a signed PCM-width value into the signed 16-bit range.
    function automatic sample_t sat16(input pcm_t x);
        sample_t r;
        if (x > PCM_HI) begin
            r = SAT_MAX;
        end else if (x < PCM_LO) begin
            r = SAT_MIN;
        end else begin
            r = SAMPLE_W'(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered level/full/empty, threshold flag
// and a sticky overflow flag for pushes dropped while full.
module sync_fifo #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     thresh_hit,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_nxt_c;
    logic [LW-1:0]    level_nxt_c;
    logic [WIDTH-1:0] head_nxt_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;

    // A push into a full FIFO only lands if a pop frees a slot on the same edge
    assign pop_c        = rd_en & ~empty;
    assign push_c       = wr_en & (~full | pop_c);
    assign drop_c       = wr_en & full & ~pop_c;
    assign rd_ptr_nxt_c = rd_ptr_q + AW'(pop_c);
    assign level_nxt_c  = level + LW'(push_c) - LW'(pop_c);

    // Next head: bypass the write data when it becomes the head this edge
    always_comb begin
        head_nxt_c = rd_data;
        if (level_nxt_c != '0) begin
            if (push_c && (rd_ptr_nxt_c == wr_ptr_q)) begin
                head_nxt_c = wr_data;
            end else begin
                head_nxt_c = mem[rd_ptr_nxt_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            thresh_hit <= 1'b0;
            overflow   <= 1'b0;
            rd_data    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(push_c);
            rd_ptr_q   <= rd_ptr_nxt_c;
            level      <= level_nxt_c;
            empty      <= (level_nxt_c == '0);
            full       <= (level_nxt_c == LW'(DEPTH));
            thresh_hit <= (level_nxt_c >= LW'(THRESH));
            rd_data    <= head_nxt_c;
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_sample_fifo.sv
// I2S sample post-processing: optional block-average decimation, arithmetic
// scaling and 16-bit saturation, buffered in a DMA-facing FIFO.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8,
    parameter int unsigned DECIM  = 1,
    parameter int unsigned SHIFT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     i2s_done,
    input  logic [I2S_WORD_W-1:0]    i2s_data,
    input  logic                     rd_en,
    output logic [SAMPLE_W-1:0]      rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dma_req,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned LOG2_DECIM = $clog2(DECIM);
    localparam int unsigned ACC_W      = PCM_W + LOG2_DECIM;
    localparam int unsigned CNT_W      = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

    pcm_t                    pcm_c;
    pcm_t                    avg_c;
    pcm_t                    scaled_c;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum_c;
    logic [CNT_W-1:0]        dcnt_q;
    logic                    group_done_c;
    logic                    wr_pend_q;
    sample_t                 result_q;
    logic                    unused_lsb_c;

    // Sample is the top 24 bits of the left-justified word; low byte is padding
    assign pcm_c        = i2s_data[I2S_WORD_W-1 -: PCM_W];
    assign unused_lsb_c = ^i2s_data[I2S_WORD_W-PCM_W-1:0];

    assign acc_sum_c    = acc_q + ACC_W'(pcm_c);
    assign avg_c        = PCM_W'(acc_sum_c >>> LOG2_DECIM);
    assign scaled_c     = avg_c >>> SHIFT;
    assign group_done_c = (dcnt_q == CNT_W'(DECIM - 1));

    // Accumulate a group; the closing sample loads the result and requests a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            dcnt_q    <= '0;
            wr_pend_q <= 1'b0;
            result_q  <= '0;
        end else begin
            wr_pend_q <= 1'b0;
            if (!en) begin
                acc_q  <= '0;
                dcnt_q <= '0;
            end else if (i2s_done) begin
                if (group_done_c) begin
                    result_q  <= sat16(scaled_c);
                    wr_pend_q <= 1'b1;
                    acc_q     <= '0;
                    dcnt_q    <= '0;
                end else begin
                    acc_q  <= acc_sum_c;
                    dcnt_q <= dcnt_q + CNT_W'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH  (SAMPLE_W),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_pend_q),
        .wr_data    (result_q),
        .rd_en      (rd_en),
        .ovf_clr    (ovf_clr),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .thresh_hit (dma_req),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Three instances (plain scaling, no-shift saturation, 4x decimation) share one
// stimulus stream; a queue-based model is compared every cycle.
module tb_i2s_sample_fifo;

    localparam int NI    = 3;
    localparam int MDEP  = 16;
    localparam int MTHR  = 8;
    localparam int DEC [NI] = '{1, 1, 4};
    localparam int LG  [NI] = '{0, 0, 2};
    localparam int SHF [NI] = '{8, 0, 0};

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic        i2s_done = 1'b0;
    logic        rd_en    = 1'b0;
    logic        ovf_clr  = 1'b0;
    logic [31:0] i2s_data = '0;

    logic [15:0] rd_data  [NI];
    logic        empty    [NI];
    logic        full     [NI];
    logic [4:0]  level    [NI];
    logic        dma_req  [NI];
    logic        overflow [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2s_sample_fifo #(.DEPTH(16), .THRESH(8), .DECIM(1), .SHIFT(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .i2s_done(i2s_done), .i2s_data(i2s_data),
        .rd_en(rd_en), .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]),
        .level(level[0]), .dma_req(dma_req[0]), .overflow(overflow[0]), .ovf_clr(ovf_clr));

    i2s_sample_fifo #(.DEPTH(16), .THRESH(8), .DECIM(1), .SHIFT(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .i2s_done(i2s_done), .i2s_data(i2s_data),
        .rd_en(rd_en), .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]),
        .level(level[1]), .dma_req(dma_req[1]), .overflow(overflow[1]), .ovf_clr(ovf_clr));

    i2s_sample_fifo #(.DEPTH(16), .THRESH(8), .DECIM(4), .SHIFT(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .i2s_done(i2s_done), .i2s_data(i2s_data),
        .rd_en(rd_en), .rd_data(rd_data[2]), .empty(empty[2]), .full(full[2]),
        .level(level[2]), .dma_req(dma_req[2]), .overflow(overflow[2]), .ovf_clr(ovf_clr));

    // Model state: stored entries, running group sum, pending result, flags
    logic [15:0] mq [NI][$];
    int          macc  [NI];
    int          mcnt  [NI];
    bit          mpend [NI];
    logic [15:0] mpval [NI];
    bit          movf  [NI];
    logic [15:0] mrd   [NI];

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] scale(input int sum, input int k);
        int s;
        s = (sum >>> LG[k]) >>> SHF[k];
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mq[k].delete();
            macc[k]  = 0;
            mcnt[k]  = 0;
            mpend[k] = 1'b0;
            mpval[k] = '0;
            movf[k]  = 1'b0;
            mrd[k]   = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            int lvl;
            bit pop;
            bit drop;
            lvl  = mq[k].size();
            pop  = rd_en && (lvl > 0);
            drop = 1'b0;
            if (pop) void'(mq[k].pop_front());
            if (mpend[k]) begin
                if (lvl < MDEP || pop) mq[k].push_back(mpval[k]);
                else drop = 1'b1;
            end
            if (drop) movf[k] = 1'b1;
            else if (ovf_clr) movf[k] = 1'b0;
            if (mq[k].size() > 0) mrd[k] = mq[k][0];
            mpend[k] = 1'b0;
            if (!en) begin
                macc[k] = 0;
                mcnt[k] = 0;
            end else if (i2s_done) begin
                macc[k] += int'($signed(i2s_data[31:8]));
                mcnt[k]++;
                if (mcnt[k] == DEC[k]) begin
                    mpval[k] = scale(macc[k], k);
                    mpend[k] = 1'b1;
                    macc[k]  = 0;
                    mcnt[k]  = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
        #1;
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                chk("rd_data",  k, int'(rd_data[k]),  int'(mrd[k]));
                chk("level",    k, int'(level[k]),    mq[k].size());
                chk("empty",    k, int'(empty[k]),    int'(mq[k].size() == 0));
                chk("full",     k, int'(full[k]),     int'(mq[k].size() == MDEP));
                chk("dma_req",  k, int'(dma_req[k]),  int'(mq[k].size() >= MTHR));
                chk("overflow", k, int'(overflow[k]), int'(movf[k]));
            end
        end
    end

    task automatic cyc(input bit d, input logic [31:0] w, input bit r, input bit c);
        i2s_done = d;
        i2s_data = w;
        rd_en    = r;
        ovf_clr  = c;
        @(negedge clk);
        i2s_done = 1'b0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        idle(2);
        for (int k = 0; k < NI; k++) begin
            chk("rst_empty",    k, int'(empty[k]),    1);
            chk("rst_full",     k, int'(full[k]),     0);
            chk("rst_level",    k, int'(level[k]),    0);
            chk("rst_dma",      k, int'(dma_req[k]),  0);
            chk("rst_ovf",      k, int'(overflow[k]), 0);
            chk("rst_rd_data",  k, int'(rd_data[k]),  0);
        end
        rst = 1'b0;
        en  = 1'b1;

        // Scaling by 8 and a pop-on-empty
        cyc(1, 32'h12345600, 0, 0);
        cyc(1, 32'hFFFF0000, 0, 0);
        idle(2);
        chk("scale_head", 0, int'(rd_data[0]), 16'h1234);
        chk("scale_lvl",  0, int'(level[0]),   2);
        chk("sat_big",    1, int'(rd_data[1]), 16'h7FFF);
        cyc(0, '0, 1, 0);
        chk("scale_neg",  0, int'(rd_data[0]), 16'hFFFF);
        chk("noshift_neg", 1, int'(rd_data[1]), 16'hFF00);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        chk("hold_empty", 0, int'(empty[0]),   1);
        chk("hold_data",  0, int'(rd_data[0]), 16'hFFFF);
        en = 1'b0; idle(1); en = 1'b1;

        // Saturation; the second word's cycle also pops into an empty FIFO
        cyc(1, 32'h7FFFFF00, 0, 0);
        cyc(1, 32'h80000000, 1, 0);
        cyc(1, 32'h00012300, 0, 0);
        idle(2);
        chk("sat_lvl",  1, int'(level[1]),   3);
        chk("sat_max",  1, int'(rd_data[1]), 16'h7FFF);
        cyc(0, '0, 1, 0);
        chk("sat_min",  1, int'(rd_data[1]), 16'h8000);
        chk("shift_min", 0, int'(rd_data[0]), 16'h8000);
        cyc(0, '0, 1, 0);
        chk("sat_pass", 1, int'(rd_data[1]), 16'h0123);
        chk("shift_small", 0, int'(rd_data[0]), 16'h0001);
        cyc(0, '0, 1, 0);
        en = 1'b0; idle(1); en = 1'b1;

        // Decimation by 4: one entry, visible two cycles after the 4th strobe
        cyc(1, 32'h00010000, 0, 0);
        cyc(1, 32'h00020000, 0, 0);
        cyc(1, 32'h00030000, 0, 0);
        cyc(1, 32'h00040000, 0, 0);
        chk("dec_lvl_n1", 2, int'(level[2]), 0);
        idle(1);
        chk("dec_lvl_n2", 2, int'(level[2]), 1);
        chk("dec_avg",    2, int'(rd_data[2]), 16'h0280);
        repeat (4) cyc(0, '0, 1, 0);

        // Overflow: 17 pushes, read back 1..16 with threshold tracking
        for (int i = 1; i <= 17; i++) cyc(1, 32'(i) << 16, 0, 0);
        idle(2);
        chk("ovf_full",  0, int'(full[0]),     1);
        chk("ovf_level", 0, int'(level[0]),    16);
        chk("ovf_flag",  0, int'(overflow[0]), 1);
        for (int j = 1; j <= 16; j++) begin
            chk("rdback",  0, int'(rd_data[0]), j);
            chk("rd_dma",  0, int'(dma_req[0]), int'((17 - j) >= 8));
            cyc(0, '0, 1, 0);
        end
        chk("no_17th",   0, int'(empty[0]),   1);
        chk("last_head", 0, int'(rd_data[0]), 16);
        cyc(0, '0, 0, 1);
        chk("ovf_clr",   0, int'(overflow[0]), 0);
        en = 1'b0; idle(1); en = 1'b1;

        // Push and pop on the same edge while full
        for (int i = 1; i <= 16; i++) cyc(1, 32'(i) << 16, 0, 0);
        idle(2);
        chk("refill_lvl", 0, int'(level[0]), 16);
        cyc(1, 32'd100 << 16, 0, 0);
        cyc(0, '0, 1, 0);
        chk("conc_lvl",  0, int'(level[0]),    16);
        chk("conc_ovf",  0, int'(overflow[0]), 0);
        chk("conc_head", 0, int'(rd_data[0]),  2);
        en = 1'b0; idle(1); en = 1'b1;
        repeat (16) cyc(0, '0, 1, 0);

        // Reset mid-group with 5 averaged entries stored
        repeat (22) cyc(1, 32'h00010000, 0, 0);
        chk("pre_rst_lvl", 2, int'(level[2]), 5);
        rst = 1'b1;
        #1;
        chk("rst_now_empty", 2, int'(empty[2]), 1);
        chk("rst_now_lvl",   2, int'(level[2]), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 32'h00001000, 0, 0);
        cyc(1, 32'h00002000, 0, 0);
        cyc(1, 32'h00003000, 0, 0);
        cyc(1, 32'h00004000, 0, 0);
        idle(2);
        chk("post_rst_lvl", 2, int'(level[2]),   1);
        chk("post_rst_avg", 2, int'(rd_data[2]), 16'h0028);

        // Drop enable mid-group: partial discarded, stored entry still readable
        cyc(1, 32'h00050000, 0, 0);
        cyc(1, 32'h00050000, 0, 0);
        en = 1'b0;
        idle(2);
        chk("en_off_data", 2, int'(rd_data[2]), 16'h0028);
        chk("en_off_lvl",  2, int'(level[2]),   1);
        en = 1'b1;
        repeat (4) cyc(1, 32'h00080000, 0, 0);
        idle(2);
        chk("en_on_lvl",  2, int'(level[2]),   2);
        cyc(0, '0, 1, 0);
        chk("en_on_avg",  2, int'(rd_data[2]), 16'h0800);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_sample_fifo.md
Name: i2s_sample_fifo

Overview:
- Stage directly downstream of the i2s receiver. Consumes each 32-bit word (i2s_data) qualified by its one-cycle i2s_done pulse.
- Extracts the 24-bit signed PCM sample, optionally decimates by block averaging, then scales and saturates to 16 bits.
- Buffers results in a show-ahead FIFO and raises dma_req to the DMAC when the fill level reaches a threshold.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, range 4..64.
- THRESH, 8, dma_req asserts when level >= THRESH; range 1..DEPTH.
- DECIM, 1, number of samples averaged per output; power of 2, range 1..16.
- SHIFT, 8, arithmetic right shift applied after averaging, before saturation; range 0..8.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable.
- i2s_done  in  1  one-cycle strobe; i2s_data is valid in that cycle.
- i2s_data  in  32  received word, MSB-first left-justified; sample = i2s_data[31:8].
- rd_en  in  1  DMAC pop request.
- rd_data  out  16  head of FIFO (show-ahead).
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(DEPTH)+1  current occupancy.
- dma_req  out  1  level >= THRESH.
- overflow  out  1  sticky flag: a sample was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (async, rst=1): pointers, level, accumulator and decimation counter all 0. Outputs: empty=1, full=0, dma_req=0, overflow=0, rd_data=0.
- Stage 1 (accumulate):
  - On an edge with en=1 and i2s_done=1: acc += sext(i2s_data[31:8]); dcnt++.
  - acc width is 24+log2(DECIM).
  - When dcnt reaches DECIM-1, that same edge loads the result register, sets wr_pend=1, and clears acc and dcnt.
  - Result = sat16((acc_final >>> log2(DECIM)) >>> SHIFT).
  - Both shifts are arithmetic and truncate toward minus infinity.
  - sat16 clamps to 0x7FFF / 0x8000.
- Stage 2 (write): wr_pend=1 pushes the result at the next edge.
- Latency: i2s_done in cycle N completing a group -> entry written at end of cycle N+1 -> level/empty update visible in cycle N+2.
- With DECIM=1, every i2s_done produces one entry.
- i2s_done is ignored while en=0. Falling en clears acc, dcnt and any pending partial group. FIFO contents are retained and reads still work.
- Pop: rd_en=1 with empty=0 advances rd_ptr. rd_data shows the new head in the following cycle. rd_en with empty=1 is ignored; no state change.
- Push with full=1:
  - Without a simultaneous pop: the entry is dropped and overflow is set (sticky).
  - With a simultaneous pop: both push and pop succeed and level is unchanged.
- Simultaneous push and pop when empty=1: push occurs, pop is ignored, level becomes 1.
- Pointers wrap modulo DEPTH. level = wr_count - rd_count, range 0..DEPTH.
- full = (level == DEPTH). empty = (level == 0). dma_req = (level >= THRESH). All three are registered-derived and glitch-free.
- overflow clears on ovf_clr=1. If ovf_clr and a drop occur on the same edge, set wins.
- rd_data holds the last head value while empty; it is not re-zeroed after reset exit.

Decomposition:
- Shared package i2s_pkg holds:
  - I2S_WORD_W=32, PCM_W=24, SAMPLE_W=16.
  - SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
  - A sat16 function.
- One sub-module, sync_fifo: parameterised width/depth, show-ahead, with level/full/empty. Reusable by other DMAC-facing peripherals.
- Decimation and scaling stay in the top module.

Test Plan:
- Scaling (DECIM=1, SHIFT=8): i2s_data=0x12345600 -> rd_data=0x1234; i2s_data=0xFFFF0000 -> rd_data=0xFFFF. Second entry observed after one rd_en.
- Saturation (SHIFT=0): i2s_data 0x7FFFFF00 -> 0x7FFF; i2s_data 0x80000000 -> 0x8000; i2s_data 0x00012300 -> 0x0123.
- Decimation (DECIM=4, SHIFT=0): samples 0x000100, 0x000200, 0x000300, 0x000400 -> exactly one entry 0x0280. Level goes 0 -> 1 two cycles after the 4th i2s_done.
- Overflow (DEPTH=16): 17 pushes, no pops -> full=1, level=16, overflow=1. The 16 entries read back in order and the 17th is absent. ovf_clr -> overflow=0.
- Threshold and concurrency (THRESH=8):
  - dma_req rises in the cycle level becomes 8 and falls when a pop brings level to 7.
  - Push and pop on the same edge at level 16 -> level stays 16, overflow stays 0.
- Reset and enable:
  - Assert rst mid-group (after 2 of 4 samples) with 5 entries stored -> immediately empty=1, level=0. The next 4 samples yield an average over those 4 only.
  - Deassert en mid-group -> partial group discarded and stored entries still readable.
